pc_sequencer: RTL

//  Owns the program counter and produces the 2-bit next-PC select feeding the
//  4:1 PC-source mux (00 seq, 01 branch, 10 jump, 11 trap). Arbitrates redirect

---
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the fetch program counter. It arbitrates redirect requests
//   (trap > jalr > jal > branch), holds the PC under the valid/ready fetch
//   handshake, and buffers a redirect that arrives while a fetch is
//   outstanding. It also pulses flush to IF/ID when a redirect lands.
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   stall_i            blocks sequential advance only
//   if_ready_i         instruction memory accepts pc_o this cycle
//   br_taken_i/_target branch redirect
//   jal_i/_target      JAL redirect
//   jalr_i/_target     JALR redirect (bit0 cleared internally)
//   trap_i             redirect to TRAP_VEC
//   if_req_o           fetch request valid
//   pc_o               fetch address
//   pcsrc_o            select of last PC update (00 seq, 01 br, 10 jump, 11 trap)
//   flush_o            1-cycle pulse when a redirect updates the PC
//   misalign_o         1-cycle pulse when a redirect target had bit1 set
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        if_ready_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        jal_i,
   input  logic [31:0] jal_target_i,
   input  logic        jalr_i,
   input  logic [31:0] jalr_target_i,
   input  logic        trap_i,
   output logic        if_req_o,
   output logic [31:0] pc_o,
   output logic [1:0]  pcsrc_o,
   output logic        flush_o,
   output logic        misalign_o
);

   typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [1:0]  r_pcsrc;
   logic        r_req;
   logic        r_flush;
   logic        r_mis;
   logic [31:0] r_pend_tgt;
   logic [1:0]  r_pend_sel;

   logic        w_redir;
   logic        w_mis;
   logic [31:0] w_raw;
   logic [31:0] w_tgt;
   logic [1:0]  w_sel;

   // Redirect arbitration. A target with bit1 set becomes a trap.
   always_comb begin
      w_redir = trap_i | jalr_i | jal_i | br_taken_i;
      w_raw   = br_target_i;
      w_sel   = 2'b01;
      if (trap_i) begin
         w_raw = TRAP_VEC;
         w_sel = 2'b11;
      end else if (jalr_i) begin
         w_raw = {jalr_target_i[31:1], 1'b0};
         w_sel = 2'b10;
      end else if (jal_i) begin
         w_raw = jal_target_i;
         w_sel = 2'b10;
      end
      w_mis = w_redir & ~trap_i & w_raw[1];
      w_tgt = w_raw;
      if (w_mis) begin
         w_tgt = TRAP_VEC;
         w_sel = 2'b11;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= BOOT;
         r_pc       <= RESET_PC;
         r_pcsrc    <= 2'b00;
         r_req      <= 1'b0;
         r_flush    <= 1'b0;
         r_mis      <= 1'b0;
         r_pend_tgt <= '0;
         r_pend_sel <= 2'b00;
      end else begin
         r_flush <= 1'b0;
         r_mis   <= 1'b0;
         case (r_state)
            BOOT: begin
               r_state <= RUN;
               r_req   <= 1'b1;
            end
            RUN: begin
               if (w_redir) begin
                  r_mis <= w_mis;
                  if (if_ready_i) begin
                     // A redirect ignores stall_i.
                     r_pc    <= w_tgt;
                     r_pcsrc <= w_sel;
                     r_flush <= 1'b1;
                  end else begin
                     // The fetch is still outstanding, so pc_o must stay put.
                     r_pend_tgt <= w_tgt;
                     r_pend_sel <= w_sel;
                     r_state    <= PEND;
                  end
               end else if (if_ready_i && !stall_i) begin
                  r_pc    <= r_pc + 32'd4;
                  r_pcsrc <= 2'b00;
               end
            end
            PEND: begin
               // Only a trap can override a buffered redirect. Other redirects
               // come from the wrong path.
               if (if_ready_i) begin
                  r_pc    <= trap_i ? TRAP_VEC : r_pend_tgt;
                  r_pcsrc <= trap_i ? 2'b11 : r_pend_sel;
                  r_flush <= 1'b1;
                  r_state <= RUN;
               end else if (trap_i) begin
                  r_pend_tgt <= TRAP_VEC;
                  r_pend_sel <= 2'b11;
               end
            end
            default: r_state <= BOOT;
         endcase
      end
   end

   assign if_req_o   = r_req;
   assign pc_o       = r_pc;
   assign pcsrc_o    = r_pcsrc;
   assign flush_o    = r_flush;
   assign misalign_o = r_mis;

endmodule
